// File: rtl/tx_arb_pkg.sv
// Shared definitions for the TX AXI-stream packet arbiter: source encodings and arbiter FSM states.
package tx_arb_pkg;

    localparam logic SRC_RE = 1'b0;
    localparam logic SRC_CU = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCK_RE = 2'd1,
        ARB_LOCK_CU = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axis_field_mux2.sv
// Pure combinational 2:1 select of the seven AXI-stream fields; sel=0 picks a, sel=1 picks b.
module axis_field_mux2 #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 10,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 232
) (
    input  logic                  i_sel,
    input  logic [DATA_WIDTH-1:0] i_a_tdata,
    input  logic [KEEP_WIDTH-1:0] i_a_tkeep,
    input  logic                  i_a_tvalid,
    input  logic                  i_a_tlast,
    input  logic [ID_WIDTH-1:0]   i_a_tid,
    input  logic [DEST_WIDTH-1:0] i_a_tdest,
    input  logic [USER_WIDTH-1:0] i_a_tuser,
    input  logic [DATA_WIDTH-1:0] i_b_tdata,
    input  logic [KEEP_WIDTH-1:0] i_b_tkeep,
    input  logic                  i_b_tvalid,
    input  logic                  i_b_tlast,
    input  logic [ID_WIDTH-1:0]   i_b_tid,
    input  logic [DEST_WIDTH-1:0] i_b_tdest,
    input  logic [USER_WIDTH-1:0] i_b_tuser,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic [KEEP_WIDTH-1:0] o_tkeep,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    output logic [ID_WIDTH-1:0]   o_tid,
    output logic [DEST_WIDTH-1:0] o_tdest,
    output logic [USER_WIDTH-1:0] o_tuser
);

    assign o_tdata  = i_sel ? i_b_tdata  : i_a_tdata;
    assign o_tkeep  = i_sel ? i_b_tkeep  : i_a_tkeep;
    assign o_tvalid = i_sel ? i_b_tvalid : i_a_tvalid;
    assign o_tlast  = i_sel ? i_b_tlast  : i_a_tlast;
    assign o_tid    = i_sel ? i_b_tid    : i_a_tid;
    assign o_tdest  = i_sel ? i_b_tdest  : i_a_tdest;
    assign o_tuser  = i_sel ? i_b_tuser  : i_a_tuser;

endmodule

// File: rtl/tx_axis_pkt_arbiter.sv
// Packet-boundary 2:1 arbiter (RDMA re_* vs compute cu_*) onto one TX AXI-stream, with re priority
// bounded by a burst counter and per-source packet statistics.
//   state       | meaning
//   ARB_IDLE    | unlocked; selection decided combinationally each cycle
//   ARB_LOCK_RE | re packet in flight, held until its tlast transfer
//   ARB_LOCK_CU | cu packet in flight, held until its tlast transfer
module tx_axis_pkt_arbiter
    import tx_arb_pkg::*;
#(
    parameter int PORTS              = 1,
    parameter int AXIS_DATA_WIDTH    = 512*2**$clog2(PORTS),
    parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH/8,
    parameter int AXIS_TX_ID_WIDTH   = 10,
    parameter int AXIS_TX_DEST_WIDTH = $clog2(PORTS)+4,
    parameter int AXIS_TX_USER_WIDTH = 232,
    parameter int MAX_BURST          = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [AXIS_DATA_WIDTH-1:0]    re_tx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    re_tx_axis_tkeep,
    input  logic                          re_tx_axis_tvalid,
    input  logic                          re_tx_axis_tlast,
    input  logic [AXIS_TX_ID_WIDTH-1:0]   re_tx_axis_tid,
    input  logic [AXIS_TX_DEST_WIDTH-1:0] re_tx_axis_tdest,
    input  logic [AXIS_TX_USER_WIDTH-1:0] re_tx_axis_tuser,
    output logic                          re_tx_axis_tready,

    input  logic [AXIS_DATA_WIDTH-1:0]    cu_tx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    cu_tx_axis_tkeep,
    input  logic                          cu_tx_axis_tvalid,
    input  logic                          cu_tx_axis_tlast,
    input  logic [AXIS_TX_ID_WIDTH-1:0]   cu_tx_axis_tid,
    input  logic [AXIS_TX_DEST_WIDTH-1:0] cu_tx_axis_tdest,
    input  logic [AXIS_TX_USER_WIDTH-1:0] cu_tx_axis_tuser,
    output logic                          cu_tx_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0]    tx_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    tx_axis_tkeep,
    output logic                          tx_axis_tvalid,
    output logic                          tx_axis_tlast,
    output logic [AXIS_TX_ID_WIDTH-1:0]   tx_axis_tid,
    output logic [AXIS_TX_DEST_WIDTH-1:0] tx_axis_tdest,
    output logic [AXIS_TX_USER_WIDTH-1:0] tx_axis_tuser,
    input  logic                          tx_axis_tready,

    output logic                          arb_busy,
    output logic                          arb_grant,
    output logic [CNT_WIDTH-1:0]          re_pkt_cnt,
    output logic [CNT_WIDTH-1:0]          cu_pkt_cnt
);

    localparam int BW = $clog2(MAX_BURST+1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [BW-1:0]          r_burst_cnt;
    logic [CNT_WIDTH-1:0]   r_re_pkt_cnt;
    logic [CNT_WIDTH-1:0]   r_cu_pkt_cnt;

    logic                   w_sel;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_xfer;
    logic                   w_pkt_done;

    axis_field_mux2 #(
        .DATA_WIDTH (AXIS_DATA_WIDTH),
        .KEEP_WIDTH (AXIS_KEEP_WIDTH),
        .ID_WIDTH   (AXIS_TX_ID_WIDTH),
        .DEST_WIDTH (AXIS_TX_DEST_WIDTH),
        .USER_WIDTH (AXIS_TX_USER_WIDTH)
    ) u_mux (
        .i_sel      (w_sel),
        .i_a_tdata  (re_tx_axis_tdata),
        .i_a_tkeep  (re_tx_axis_tkeep),
        .i_a_tvalid (re_tx_axis_tvalid),
        .i_a_tlast  (re_tx_axis_tlast),
        .i_a_tid    (re_tx_axis_tid),
        .i_a_tdest  (re_tx_axis_tdest),
        .i_a_tuser  (re_tx_axis_tuser),
        .i_b_tdata  (cu_tx_axis_tdata),
        .i_b_tkeep  (cu_tx_axis_tkeep),
        .i_b_tvalid (cu_tx_axis_tvalid),
        .i_b_tlast  (cu_tx_axis_tlast),
        .i_b_tid    (cu_tx_axis_tid),
        .i_b_tdest  (cu_tx_axis_tdest),
        .i_b_tuser  (cu_tx_axis_tuser),
        .o_tdata    (tx_axis_tdata),
        .o_tkeep    (tx_axis_tkeep),
        .o_tvalid   (w_sel_valid),
        .o_tlast    (w_sel_last),
        .o_tid      (tx_axis_tid),
        .o_tdest    (tx_axis_tdest),
        .o_tuser    (tx_axis_tuser)
    );

    // rst gates the handshake outputs combinationally so they drop the instant reset asserts
    assign w_xfer            = w_sel_valid && tx_axis_tready && !rst;
    assign w_pkt_done        = w_xfer && w_sel_last;
    assign tx_axis_tvalid    = w_sel_valid && !rst;
    assign tx_axis_tlast     = w_sel_last;
    assign re_tx_axis_tready = !rst && (w_sel == SRC_RE) && tx_axis_tready;
    assign cu_tx_axis_tready = !rst && (w_sel == SRC_CU) && tx_axis_tready;
    assign arb_busy          = (r_state != ARB_IDLE);
    assign arb_grant         = !rst && w_sel;
    assign re_pkt_cnt        = r_re_pkt_cnt;
    assign cu_pkt_cnt        = r_cu_pkt_cnt;

    always_comb begin
        w_sel       = SRC_RE;
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (cu_tx_axis_tvalid && (!re_tx_axis_tvalid || r_burst_cnt == BURST_MAX))
                    w_sel = SRC_CU;
            end
            ARB_LOCK_RE: w_sel = SRC_RE;
            ARB_LOCK_CU: w_sel = SRC_CU;
            default:     w_sel = SRC_RE;
        endcase
        if (w_xfer) begin
            if (w_sel_last)
                w_state_nxt = ARB_IDLE;
            else if (r_state == ARB_IDLE)
                w_state_nxt = (w_sel == SRC_CU) ? ARB_LOCK_CU : ARB_LOCK_RE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_burst_cnt  <= '0;
            r_re_pkt_cnt <= '0;
            r_cu_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pkt_done) begin
                if (w_sel == SRC_RE) begin
                    r_re_pkt_cnt <= r_re_pkt_cnt + CNT_WIDTH'(1);
                    if (r_burst_cnt != BURST_MAX)
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                end else begin
                    r_cu_pkt_cnt <= r_cu_pkt_cnt + CNT_WIDTH'(1);
                    r_burst_cnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_axis_pkt_arbiter.sv
// Directed bench for tx_axis_pkt_arbiter: priority, locking, fairness, backpressure, bubbles and reset.
module tb_tx_axis_pkt_arbiter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int IW = 10;
    localparam int SW = 4;
    localparam int UW = 232;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] re_tdata, cu_tdata, tx_tdata;
    logic [KW-1:0] re_tkeep, cu_tkeep, tx_tkeep;
    logic          re_tvalid, cu_tvalid, tx_tvalid;
    logic          re_tlast, cu_tlast, tx_tlast;
    logic [IW-1:0] re_tid, cu_tid, tx_tid;
    logic [SW-1:0] re_tdest, cu_tdest, tx_tdest;
    logic [UW-1:0] re_tuser, cu_tuser, tx_tuser;
    logic          re_tready, cu_tready, tx_tready;
    logic          arb_busy, arb_grant;
    logic [CW-1:0] re_pkt_cnt, cu_pkt_cnt;

    int n_chk = 0;
    int n_err = 0;

    tx_axis_pkt_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .re_tx_axis_tdata  (re_tdata),
        .re_tx_axis_tkeep  (re_tkeep),
        .re_tx_axis_tvalid (re_tvalid),
        .re_tx_axis_tlast  (re_tlast),
        .re_tx_axis_tid    (re_tid),
        .re_tx_axis_tdest  (re_tdest),
        .re_tx_axis_tuser  (re_tuser),
        .re_tx_axis_tready (re_tready),
        .cu_tx_axis_tdata  (cu_tdata),
        .cu_tx_axis_tkeep  (cu_tkeep),
        .cu_tx_axis_tvalid (cu_tvalid),
        .cu_tx_axis_tlast  (cu_tlast),
        .cu_tx_axis_tid    (cu_tid),
        .cu_tx_axis_tdest  (cu_tdest),
        .cu_tx_axis_tuser  (cu_tuser),
        .cu_tx_axis_tready (cu_tready),
        .tx_axis_tdata     (tx_tdata),
        .tx_axis_tkeep     (tx_tkeep),
        .tx_axis_tvalid    (tx_tvalid),
        .tx_axis_tlast     (tx_tlast),
        .tx_axis_tid       (tx_tid),
        .tx_axis_tdest     (tx_tdest),
        .tx_axis_tuser     (tx_tuser),
        .tx_axis_tready    (tx_tready),
        .arb_busy          (arb_busy),
        .arb_grant         (arb_grant),
        .re_pkt_cnt        (re_pkt_cnt),
        .cu_pkt_cnt        (cu_pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle's inputs mid-cycle; outputs settle 1ns later, well away from the rising edge
    task automatic drive(input logic rv, input logic rl, input logic [31:0] rd,
                         input logic cv, input logic cl, input logic [31:0] cd,
                         input logic tr);
        @(negedge clk);
        re_tvalid = rv; re_tlast = rl; re_tdata = {{(DW-32){1'b0}}, rd};
        cu_tvalid = cv; cu_tlast = cl; cu_tdata = {{(DW-32){1'b0}}, cd};
        tx_tready = tr;
        #1;
    endtask

    logic [9:0] fair_pat;
    logic       tr;
    int         b;

    initial begin
        re_tkeep = '1;               cu_tkeep = {KW{1'b0}} | 64'h0F;
        re_tid   = 10'h011;          cu_tid   = 10'h022;
        re_tdest = 4'h3;             cu_tdest = 4'hA;
        re_tuser = {UW{1'b0}} | 8'h5A; cu_tuser = {UW{1'b0}} | 8'hC3;
        re_tvalid = 1'b1; re_tlast = 1'b0; re_tdata = '0;
        cu_tvalid = 1'b1; cu_tlast = 1'b1; cu_tdata = '0;
        tx_tready = 1'b1;

        // reset state with both sources valid
        #12;
        chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("rst_re_rdy", 64'(re_tready), 64'd0);
        chk("rst_cu_rdy", 64'(cu_tready), 64'd0);
        chk("rst_busy",   64'(arb_busy),  64'd0);
        chk("rst_grant",  64'(arb_grant), 64'd0);
        chk("rst_recnt",  64'(re_pkt_cnt), 64'd0);
        chk("rst_cucnt",  64'(cu_pkt_cnt), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        // 1: re-only, two 3-beat packets back to back
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1, k == 2, 32'hA000_0000 | (p << 8) | k, 0, 0, 0, 1);
                chk("t1_tvalid", 64'(tx_tvalid), 64'd1);
                chk("t1_data",   64'(tx_tdata[31:0]), 64'(32'hA000_0000 | (p << 8) | k));
                chk("t1_last",   64'(tx_tlast), 64'(k == 2));
                chk("t1_grant",  64'(arb_grant), 64'd0);
                chk("t1_cu_rdy", 64'(cu_tready), 64'd0);
                chk("t1_re_rdy", 64'(re_tready), 64'd1);
                chk("t1_busy",   64'(arb_busy), 64'(k != 0));
            end
        end
        chk("t1_tid",  64'(tx_tid), 64'h011);
        chk("t1_user", 64'(tx_tuser[7:0]), 64'h5A);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t1_recnt", 64'(re_pkt_cnt), 64'd2);
        chk("t1_idle_tvalid", 64'(tx_tvalid), 64'd0);
        chk("t1_idle_grant",  64'(arb_grant), 64'd0);

        // 2: cu rises during an re packet and must wait for re tlast
        for (int k = 0; k < 4; k++) begin
            drive(1, k == 3, 32'hA100_0000 | k, k >= 1, 1, 32'hC000_0001, 1);
            chk("t2_data",   64'(tx_tdata[31:0]), 64'(32'hA100_0000 | k));
            chk("t2_cu_rdy", 64'(cu_tready), 64'd0);
            chk("t2_grant",  64'(arb_grant), 64'd0);
        end
        drive(0, 0, 0, 1, 1, 32'hC000_0001, 1);
        chk("t2_cu_grant", 64'(arb_grant), 64'd1);
        chk("t2_cu_rdy1",  64'(cu_tready), 64'd1);
        chk("t2_cu_data",  64'(tx_tdata[31:0]), 64'hC000_0001);
        chk("t2_cu_tid",   64'(tx_tid), 64'h022);
        chk("t2_cu_dest",  64'(tx_tdest), 64'hA);
        chk("t2_cu_keep",  64'(tx_tkeep), 64'h0F);
        chk("t2_re_rdy",   64'(re_tready), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t2_recnt", 64'(re_pkt_cnt), 64'd3);
        chk("t2_cucnt", 64'(cu_pkt_cnt), 64'd1);

        // 3: fairness with both always valid, 1-beat packets -> re x4 then cu
        fair_pat = 10'b10000_10000;
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 32'hA200_0000 | k, 1, 1, 32'hC200_0000 | k, 1);
            chk("t3_grant", 64'(arb_grant), 64'(fair_pat[k]));
            chk("t3_busy",  64'(arb_busy), 64'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t3_recnt", 64'(re_pkt_cnt), 64'd11);
        chk("t3_cucnt", 64'(cu_pkt_cnt), 64'd3);

        // 4: backpressure toggling mid-packet, cu waiting throughout
        b  = 0;
        tr = 1'b1;
        for (int c = 0; c < 20 && b < 4; c++) begin
            drive(1, b == 3, 32'hA300_0000 | b, 1, 1, 32'hC300_0000, tr);
            chk("t4_data",   64'(tx_tdata[31:0]), 64'(32'hA300_0000 | b));
            chk("t4_tvalid", 64'(tx_tvalid), 64'd1);
            chk("t4_grant",  64'(arb_grant), 64'd0);
            chk("t4_re_rdy", 64'(re_tready), 64'(tr));
            chk("t4_cu_rdy", 64'(cu_tready), 64'd0);
            if (tr) b++;
            tr = ~tr;
        end
        chk("t4_beats", 64'(b), 64'd4);
        drive(0, 0, 0, 1, 1, 32'hC300_0000, 1);
        chk("t4_cu_grant", 64'(arb_grant), 64'd1);
        chk("t4_cu_data",  64'(tx_tdata[31:0]), 64'hC300_0000);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t4_recnt", 64'(re_pkt_cnt), 64'd12);
        chk("t4_cucnt", 64'(cu_pkt_cnt), 64'd4);

        // 5: re bubble of 2 cycles mid-packet while cu is valid
        drive(1, 0, 32'hA400_0000, 1, 1, 32'hC400_0000, 1);
        chk("t5_b0_grant", 64'(arb_grant), 64'd0);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 1, 32'hC400_0000, 1);
            chk("t5_bub_tvalid", 64'(tx_tvalid), 64'd0);
            chk("t5_bub_busy",   64'(arb_busy), 64'd1);
            chk("t5_bub_grant",  64'(arb_grant), 64'd0);
            chk("t5_bub_cu_rdy", 64'(cu_tready), 64'd0);
        end
        drive(1, 0, 32'hA400_0001, 1, 1, 32'hC400_0000, 1);
        chk("t5_b1_data", 64'(tx_tdata[31:0]), 64'hA400_0001);
        drive(1, 1, 32'hA400_0002, 1, 1, 32'hC400_0000, 1);
        chk("t5_b2_data", 64'(tx_tdata[31:0]), 64'hA400_0002);
        drive(0, 0, 0, 1, 1, 32'hC400_0000, 1);
        chk("t5_cu_grant", 64'(arb_grant), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t5_recnt", 64'(re_pkt_cnt), 64'd13);
        chk("t5_cucnt", 64'(cu_pkt_cnt), 64'd5);

        // 6: async reset on beat 2 of a 5-beat re packet
        drive(1, 0, 32'hA500_0000, 0, 0, 0, 1);
        drive(1, 0, 32'hA500_0001, 1, 1, 32'hC500_0000, 1);
        chk("t6_pre_busy", 64'(arb_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("t6_rst_re_rdy", 64'(re_tready), 64'd0);
        chk("t6_rst_cu_rdy", 64'(cu_tready), 64'd0);
        chk("t6_rst_busy",   64'(arb_busy), 64'd0);
        chk("t6_rst_grant",  64'(arb_grant), 64'd0);
        chk("t6_rst_recnt",  64'(re_pkt_cnt), 64'd0);
        chk("t6_rst_cucnt",  64'(cu_pkt_cnt), 64'd0);
        drive(0, 0, 0, 1, 1, 32'hC500_0000, 1);
        rst = 1'b0;
        #1;
        chk("t6_cu_tvalid", 64'(tx_tvalid), 64'd1);
        chk("t6_cu_grant",  64'(arb_grant), 64'd1);
        chk("t6_cu_rdy",    64'(cu_tready), 64'd1);
        chk("t6_cu_data",   64'(tx_tdata[31:0]), 64'hC500_0000);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t6_cucnt", 64'(cu_pkt_cnt), 64'd1);
        chk("t6_recnt", 64'(re_pkt_cnt), 64'd0);
        chk("t6_busy",  64'(arb_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
